// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared types for the SRAM arbiter: controller state encoding and
//   requester identifiers. No ports.
package sram_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    CPU = 1'b0,
    VID = 1'b1
  } req_id_t;

endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one off-chip SRAM between the CPU and the video fetch engine.
//   Serialises requests with round-robin arbitration, holds Mem_OE/Mem_WE
//   for WAIT_CYCLES cycles, and returns read data with a one-cycle done
//   pulse to the requester that was served.
//
//   Ports:
//     Clk, Reset                 clock, synchronous active-high reset
//     cpu_req/we/addr/wdata      CPU request (level, held until cpu_done)
//     cpu_rdata, cpu_done        CPU read data and completion pulse
//     vid_req/addr               video read request (level, held until vid_done)
//     vid_rdata, vid_done        video read data and completion pulse
//     busy                       high whenever the controller is not idle
//     mem_addr/wdata/rdata       SRAM address and data
//     Mem_OE, Mem_WE             active-high strobes, inverted at the pins
//
//   state  | meaning
//   IDLE   | waiting for a request; grants and latches it on the edge
//   ACCESS | strobe asserted, wait counter counting down to 1
//   DONE   | done pulse to the granted requester, strobes low
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  arb_state_t        state_q, state_d;
  req_id_t           last_grant_q, grant_d;
  logic              grant_go;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q;
  logic              last_access;

  assign last_access = (state_q == ACCESS) && (cnt_q == CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_go = 1'b0;
    grant_d  = last_grant_q;
    Mem_OE   = 1'b0;
    Mem_WE   = 1'b0;
    busy     = 1'b1;
    cpu_done = 1'b0;
    vid_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (cpu_req || vid_req) begin
          grant_go = 1'b1;
          state_d  = ACCESS;
          // Contention goes to whoever was not served last.
          if (cpu_req && vid_req) grant_d = (last_grant_q == CPU) ? VID : CPU;
          else                    grant_d = cpu_req ? CPU : VID;
        end
      end
      ACCESS: begin
        Mem_OE = ~we_q;
        Mem_WE = we_q;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        cpu_done = (last_grant_q == CPU);
        vid_done = (last_grant_q == VID);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant_q doubles as the current grantee while ACCESS/DONE are active.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant_q <= VID;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      vid_rdata_q  <= '0;
    end else if (grant_go) begin
      last_grant_q <= grant_d;
      cnt_q        <= WAIT_LD;
      addr_q       <= (grant_d == CPU) ? cpu_addr : vid_addr;
      we_q         <= (grant_d == CPU) && cpu_we;
      if (grant_d == CPU) wdata_q <= cpu_wdata;
    end else if (state_q == ACCESS) begin
      if (!last_access) cnt_q <= cnt_q - CNT_W'(1);
      if (last_access && !we_q) begin
        if (last_grant_q == CPU) cpu_rdata_q <= mem_rdata;
        else                     vid_rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  logic        Clk;
  logic        Reset;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_done;
  logic        vid_req;
  logic [19:0] vid_addr;
  logic [15:0] vid_rdata;
  logic        vid_done;
  logic        busy;
  logic [19:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        Mem_OE, Mem_WE;

  logic        rd_ovr_en;
  logic [15:0] rd_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  sram_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_done(vid_done),
    .busy(busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: address-derived data unless a test forces a value.
  assign mem_rdata = rd_ovr_en ? rd_ovr : (mem_addr[15:0] ^ 16'h5A5A);

  logic prev_cd = 1'b0, prev_vd = 1'b0;
  always @(negedge Clk) begin
    if (!Reset) begin
      n_checks++;
      if (Mem_OE && Mem_WE) begin
        n_fail++; $display("FAIL oe_we_excl: Mem_OE=%b Mem_WE=%b, required not both 1", Mem_OE, Mem_WE);
      end
      n_checks++;
      if (cpu_done && vid_done) begin
        n_fail++; $display("FAIL done_excl: cpu_done=%b vid_done=%b, required not both 1", cpu_done, vid_done);
      end
      n_checks++;
      if ((cpu_done && prev_cd) || (vid_done && prev_vd)) begin
        n_fail++; $display("FAIL done_width: done high two cycles, required one-cycle pulse");
      end
      n_checks++;
      if ((Mem_OE || Mem_WE) && !busy) begin
        n_fail++; $display("FAIL strobe_idle: strobe high while busy=0");
      end
    end
    prev_cd = cpu_done;
    prev_vd = vid_done;
  end

  // Waits for a done pulse after the grant edge, recording strobe activity.
  task automatic run_wait(input int drop_at, input logic [19:0] exp_addr,
                          output int cyc, output int oe_n, output int we_n,
                          output int addr_bad, output logic [15:0] wd_seen,
                          output bit cpu_d, output bit vid_d);
    cyc = -1; oe_n = 0; we_n = 0; addr_bad = 0; wd_seen = '0; cpu_d = 0; vid_d = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (Mem_OE) oe_n++;
      if (Mem_WE) begin we_n++; wd_seen = mem_wdata; end
      if ((Mem_OE || Mem_WE) && mem_addr !== exp_addr) addr_bad++;
      if (k == drop_at) begin cpu_req = 0; vid_req = 0; vid_addr = 20'h00077; end
      if (cpu_done || vid_done) begin
        cpu_d = cpu_done; vid_d = vid_done; cyc = k;
        break;
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; cpu_req = 0; vid_req = 0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 0; vid_addr = '0; rd_ovr_en = 0; rd_ovr = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_checks++;
    if ({Mem_OE, Mem_WE, busy, cpu_done, vid_done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: oe/we/busy/cd/vd=%b required 00000",
                         {Mem_OE, Mem_WE, busy, cpu_done, vid_done});
    end
    n_checks++;
    if (cpu_rdata !== 16'h0 || vid_rdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_rdata: cpu=%h vid=%h required 0000", cpu_rdata, vid_rdata);
    end
    n_checks++;
    if (mem_addr !== 20'h0 || mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_mem: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    int cyc, oe_n, we_n, bad; logic [15:0] wd; bit cd, vd;
    rd_ovr_en = 1; rd_ovr = 16'hBEEF;
    @(posedge Clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    @(posedge Clk);
    run_wait(0, 20'h00010, cyc, oe_n, we_n, bad, wd, cd, vd);
    cpu_req = 0;
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL rd_latency: done at cycle %0d required 4", cyc); end
    n_checks++;
    if (oe_n !== 3 || we_n !== 0) begin
      n_fail++; $display("FAIL rd_strobes: oe=%0d we=%0d required 3/0", oe_n, we_n);
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rd_addr: %0d bad cycles required 0", bad); end
    n_checks++;
    if (!cd || vd) begin n_fail++; $display("FAIL rd_done: cpu=%b vid=%b required 1/0", cd, vd); end
    n_checks++;
    if (cpu_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd_data: cpu_rdata=%h required BEEF", cpu_rdata);
    end
    @(negedge Clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: busy=%b required 0", busy); end
    rd_ovr_en = 0;
  endtask

  task automatic test_cpu_write();
    int cyc, oe_n, we_n, bad; logic [15:0] wd; bit cd, vd;
    @(posedge Clk); #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00020; cpu_wdata = 16'h1234;
    @(posedge Clk);
    run_wait(0, 20'h00020, cyc, oe_n, we_n, bad, wd, cd, vd);
    cpu_req = 0; cpu_we = 0;
    n_checks++;
    if (cyc !== 4) begin n_fail++; $display("FAIL wr_latency: done at cycle %0d required 4", cyc); end
    n_checks++;
    if (oe_n !== 0 || we_n !== 3) begin
      n_fail++; $display("FAIL wr_strobes: oe=%0d we=%0d required 0/3", oe_n, we_n);
    end
    n_checks++;
    if (wd !== 16'h1234 || bad !== 0) begin
      n_fail++; $display("FAIL wr_bus: wdata=%h badaddr=%0d required 1234/0", wd, bad);
    end
    n_checks++;
    if (!cd || vd) begin n_fail++; $display("FAIL wr_done: cpu=%b vid=%b required 1/0", cd, vd); end
    n_checks++;
    if (cpu_rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_rdata_kept: cpu_rdata=%h required BEEF", cpu_rdata);
    end
  endtask

  task automatic test_round_robin();
    bit exp_vid[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int gap;
    do_reset();
    @(posedge Clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00040;
    vid_req = 1; vid_addr = 20'h00030;
    for (int g = 0; g < 4; g++) begin
      gap = -1;
      for (int k = 1; k <= 20; k++) begin
        @(negedge Clk);
        if (cpu_done || vid_done) begin gap = k; break; end
      end
      n_checks++;
      if (gap !== 5) begin n_fail++; $display("FAIL rr_period[%0d]: gap %0d required 5", g, gap); end
      n_checks++;
      if (vid_done !== exp_vid[g] || cpu_done !== !exp_vid[g]) begin
        n_fail++; $display("FAIL rr_order[%0d]: cpu_done=%b vid_done=%b required vid=%b",
                           g, cpu_done, vid_done, exp_vid[g]);
      end
      if (g == 3) begin cpu_req = 0; vid_req = 0; end
    end
    n_checks++;
    if (cpu_rdata !== 16'h5A1A || vid_rdata !== 16'h5A6A) begin
      n_fail++; $display("FAIL rr_data: cpu=%h vid=%h required 5A1A/5A6A", cpu_rdata, vid_rdata);
    end
    @(negedge Clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_reset_mid_access();
    int cyc, oe_n, we_n, bad, dones; logic [15:0] wd; bit cd, vd;
    @(posedge Clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00099;
    @(posedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if (Mem_OE !== 1'b1) begin n_fail++; $display("FAIL rst_pre: Mem_OE=%b required 1", Mem_OE); end
    Reset = 1; cpu_req = 0;
    @(negedge Clk);
    n_checks++;
    if (Mem_OE !== 1'b0 || busy !== 1'b0 || cpu_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_abort: oe=%b busy=%b done=%b required 0/0/0", Mem_OE, busy, cpu_done);
    end
    n_checks++;
    if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata: cpu_rdata=%h required 0", cpu_rdata); end
    @(posedge Clk); #1 Reset = 0;
    dones = 0;
    repeat (6) begin @(negedge Clk); if (cpu_done || vid_done) dones++; end
    n_checks++;
    if (dones !== 0) begin n_fail++; $display("FAIL rst_no_done: %0d pulses required 0", dones); end
    @(posedge Clk); #1;
    vid_req = 1; vid_addr = 20'h00012;
    @(posedge Clk);
    run_wait(0, 20'h00012, cyc, oe_n, we_n, bad, wd, cd, vd);
    vid_req = 0;
    n_checks++;
    if (cyc !== 4 || !vd || oe_n !== 3) begin
      n_fail++; $display("FAIL rst_recover: cyc=%0d vid_done=%b oe=%0d required 4/1/3", cyc, vd, oe_n);
    end
    n_checks++;
    if (vid_rdata !== 16'h5A48) begin n_fail++; $display("FAIL rst_rec_data: vid_rdata=%h required 5A48", vid_rdata); end
  endtask

  task automatic test_vid_drop();
    int cyc, oe_n, we_n, bad; logic [15:0] wd; bit cd, vd;
    @(posedge Clk); #1;
    vid_req = 1; vid_addr = 20'h00055;
    @(posedge Clk);
    run_wait(1, 20'h00055, cyc, oe_n, we_n, bad, wd, cd, vd);
    n_checks++;
    if (cyc !== 4 || !vd || cd) begin
      n_fail++; $display("FAIL drop_done: cyc=%0d vid=%b cpu=%b required 4/1/0", cyc, vd, cd);
    end
    n_checks++;
    if (oe_n !== 3 || bad !== 0) begin
      n_fail++; $display("FAIL drop_addr: oe=%0d badaddr=%0d required 3/0", oe_n, bad);
    end
    n_checks++;
    if (vid_rdata !== 16'h5A0F) begin n_fail++; $display("FAIL drop_data: vid_rdata=%h required 5A0F", vid_rdata); end
    @(negedge Clk);
    @(negedge Clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy=%b required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_round_robin();
    test_reset_mid_access();
    test_vid_drop();
    repeat (3) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
